// File: rtl/rf_mp_scoreboard.sv
// Multi-port register file with a per-register pending scoreboard for ID-stage stall detection.
// Optional RF_BYPASS_EN macro adds same-cycle write-to-read forwarding on data and pending.
module rf_mp_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int NUM_ISS  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pending,
  input  logic [NUM_ISS-1:0]         iss_en,
  input  logic [NUM_ISS*ADDR_W-1:0]  iss_addr,
  input  logic                       flush,
  output logic                       any_pending
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Ascending port loop lets the highest-indexed write port win on a shared index.
  always_comb begin
    logic [ADDR_W-1:0] wa;
    regs_d = regs_q;
    for (int k = 0; k < NUM_WR; k++) begin
      wa = wr_addr[k*ADDR_W +: ADDR_W];
      if (wr_en[k] && wa != '0) regs_d[wa] = wr_data[k*DATA_W +: DATA_W];
    end
  end

  // Clears first, then issues, so a new producer supersedes a same-cycle write-back.
  always_comb begin
    logic [ADDR_W-1:0] pa;
    pend_d = pend_q;
    for (int k = 0; k < NUM_WR; k++) begin
      pa = wr_addr[k*ADDR_W +: ADDR_W];
      if (wr_en[k]) pend_d[pa] = 1'b0;
    end
    for (int m = 0; m < NUM_ISS; m++) begin
      pa = iss_addr[m*ADDR_W +: ADDR_W];
      if (iss_en[m]) pend_d[pa] = 1'b1;
    end
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  // NOTE: the whole array is reset here because reset must force every read to zero;
  // a plain RAM without that need should not carry a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              iss_hit;
    rd_data    = '0;
    rd_pending = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      ra = rd_addr[j*ADDR_W +: ADDR_W];
      rd_data[j*DATA_W +: DATA_W] = regs_q[ra];
      rd_pending[j]               = pend_q[ra];
`ifdef RF_BYPASS_EN
      iss_hit = 1'b0;
      for (int m = 0; m < NUM_ISS; m++)
        if (iss_en[m] && iss_addr[m*ADDR_W +: ADDR_W] == ra) iss_hit = 1'b1;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == ra && ra != '0) begin
          rd_data[j*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
          rd_pending[j]               = iss_hit;
        end
      end
`else
      iss_hit = 1'b0;
`endif
    end
  end

  assign any_pending = |pend_q;

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Scoreboard bench for rf_mp_scoreboard: expected read results are queued when a read is set up
// and popped/compared at the following negedge (or immediately for asynchronous reset checks).
module tb_rf_mp_scoreboard;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int NISS   = 2;

  typedef enum int {K_DATA, K_PEND, K_ANY} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NWR-1:0]         wr_en;
  logic [NWR*AW-1:0]      wr_addr;
  logic [NWR*DATA_W-1:0]  wr_data;
  logic [NRD*AW-1:0]      rd_addr;
  logic [NRD*DATA_W-1:0]  rd_data;
  logic [NRD-1:0]         rd_pending;
  logic [NISS-1:0]        iss_en;
  logic [NISS*AW-1:0]     iss_addr;
  logic                   flush;
  logic                   any_pending;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  rf_mp_scoreboard #(
    .DATA_W(DATA_W), .NUM_REGS(NREGS), .ADDR_W(AW),
    .NUM_RD(NRD), .NUM_WR(NWR), .NUM_ISS(NISS)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_strobes();
    wr_en = '0; iss_en = '0; flush = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    clear_strobes();
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    wr_en[port] = 1'b1;
    wr_addr[port*AW +: AW] = AW'(addr);
    wr_data[port*DATA_W +: DATA_W] = data;
  endtask

  task automatic iss(input int port, input int addr);
    iss_en[port] = 1'b1;
    iss_addr[port*AW +: AW] = AW'(addr);
  endtask

  // Point a read port at a register and queue what it must return.
  task automatic exp_rd(input string tag, input int port, input int addr,
                        input logic [31:0] data, input logic pend);
    exp_t e;
    rd_addr[port*AW +: AW] = AW'(addr);
    e.tag = {tag, "_data"}; e.kind = K_DATA; e.port = port; e.exp = data;
    sb_q.push_back(e);
    e.tag = {tag, "_pend"}; e.kind = K_PEND; e.port = port; e.exp = {31'b0, pend};
    sb_q.push_back(e);
  endtask

  task automatic exp_any(input string tag, input logic v);
    exp_t e;
    e.tag = tag; e.kind = K_ANY; e.port = 0; e.exp = {31'b0, v};
    sb_q.push_back(e);
  endtask

  task automatic score();
    exp_t        e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_DATA:  got = rd_data[e.port*DATA_W +: DATA_W];
        K_PEND:  got = {31'b0, rd_pending[e.port]};
        default: got = {31'b0, any_pending};
      endcase
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    score();
  endtask

  initial begin
    rst = 1'b1;
    clear_strobes();
    wr_addr = '0; wr_data = '0; rd_addr = '0; iss_addr = '0;

    // Reset state
    exp_rd("rst_init_r5", 0, 5, 32'h0, 1'b0);
    exp_any("rst_init_any", 1'b0);
    sample();
    cyc();
    rst = 1'b0;

    // Write r5 and mark it pending, then assert reset mid-cycle
    wr(0, 5, 32'hDEADBEEF); iss(0, 5);
    cyc();
    exp_rd("pre_rst_r5", 0, 5, 32'hDEADBEEF, 1'b1);
    exp_any("pre_rst_any", 1'b1);
    sample();
    #1 rst = 1'b1;
    #1;
    exp_rd("async_rst_r5", 0, 5, 32'h0, 1'b0);
    exp_any("async_rst_any", 1'b0);
    score();
    cyc();
    rst = 1'b0;

    // Write/read, and writes to r0 are dropped
    wr(0, 7, 32'h12345678); wr(1, 0, 32'hFFFFFFFF);
    cyc();
    exp_rd("wr_r7", 0, 7, 32'h12345678, 1'b0);
    exp_rd("wr_r0", 1, 0, 32'h0, 1'b0);
    sample();

    // Two ports write r3: port 1 wins
    wr(0, 3, 32'h1); wr(1, 3, 32'h2);
    cyc();
    exp_rd("conflict_r3", 0, 3, 32'h2, 1'b0);
    sample();

    // Issue to r0 is ignored
    iss(0, 0);
    cyc();
    exp_rd("iss_r0", 0, 0, 32'h0, 1'b0);
    exp_any("iss_r0_any", 1'b0);
    sample();

    // Scoreboard set, set-wins-over-clear, then clear
    iss(1, 9);
    cyc();
    exp_rd("iss_r9", 0, 9, 32'h0, 1'b1);
    exp_any("iss_r9_any", 1'b1);
    sample();
    wr(0, 9, 32'h99); iss(0, 9);
    cyc();
    exp_rd("set_wins_r9", 1, 9, 32'h99, 1'b1);
    sample();
    wr(1, 9, 32'h55);
    cyc();
    exp_rd("wb_r9", 0, 9, 32'h55, 1'b0);
    exp_any("wb_r9_any", 1'b0);
    sample();

    // Flush clears everything and overrides a same-cycle issue; data writes still land
    iss(0, 4); iss(1, 6);
    cyc();
    exp_rd("iss_r4", 0, 4, 32'h0, 1'b1);
    exp_rd("iss_r6", 1, 6, 32'h0, 1'b1);
    sample();
    flush = 1'b1; iss(0, 8); wr(0, 4, 32'h44);
    cyc();
    exp_rd("flush_r4", 0, 4, 32'h44, 1'b0);
    exp_rd("flush_r8", 1, 8, 32'h0, 1'b0);
    exp_any("flush_any", 1'b0);
    sample();
    exp_rd("flush_r6", 0, 6, 32'h0, 1'b0);
    sample();

    // Same-cycle write and read of r2
    wr(0, 2, 32'hA);
    cyc();
    wr(0, 2, 32'hB);
`ifdef RF_BYPASS_EN
    exp_rd("byp_same_r2", 0, 2, 32'hB, 1'b0);
`else
    exp_rd("nobyp_same_r2", 0, 2, 32'hA, 1'b0);
`endif
    sample();
    cyc();
    exp_rd("byp_next_r2", 0, 2, 32'hB, 1'b0);
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
